scan_ctrl: RTL and testbench
============================

# scan_ctrl

Sample-order sequencer for the local-difference stage of the simplified CCSDS-123.0-B-2 predictor. On a start command it walks every sample of an Nx × Ny × Nz image in BSQ order and issues one enable per accepted sample, with the matching coordinates, one-hot scan-area code and one-hot local-sum shift select. It sits directly upstream of the local-difference datapath and its neighbour line buffer. After the last sample it waits out the datapath pipeline latency, then reports completion.

## Interface
- X_WIDTH, 10, width of column counter / cfg_nx_i
- Y_WIDTH, 10, width of row counter / cfg_ny_i
- Z_WIDTH, 8, width of band counter / cfg_nz_i
- PIPE_LAT, 3, cycles from last en_o to done_o (equals datapath enable-to-output latency)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  begin a frame; honoured only in IDLE
- abort_i  in  1  synchronous abort; return to IDLE, no done_o
- cfg_nx_i  in  X_WIDTH  columns minus one; latched on accepted start
- cfg_ny_i  in  Y_WIDTH  rows minus one; latched on accepted start
- cfg_nz_i  in  Z_WIDTH  bands minus one; latched on accepted start
- cfg_sl_i  in  2  shift level; latched on accepted start
- ready_i  in  1  downstream can take a sample this cycle
- en_o  out  1  sample issued this cycle
- x_o / y_o / z_o  out  X_WIDTH / Y_WIDTH / Z_WIDTH  coordinates of the current sample
- scan_area_o  out  5  one-hot area code for the current sample
- sl_num_o  out  4  one-hot shift select
- last_o  out  1  current sample is the final sample of the frame
- busy_o  out  1  state is not IDLE
- done_o  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DRAIN. IDLE -> RUN on start_i; latch all cfg_*, clear x/y/z. In RUN, last accepted sample -> DRAIN. DRAIN -> IDLE after PIPE_LAT cycles, pulsing done_o on the exit cycle. abort_i in RUN or DRAIN -> IDLE next cycle, no done_o; abort_i wins over every other transition.
- en_o = (state==RUN) & ready_i, combinational. Counters advance only on edges where en_o=1.
- Order: x innermost (0..nx), then y (0..ny), then z (0..nz). x wraps to 0 and y increments; y wraps to 0 and z increments.
- last_o = RUN & x==nx & y==ny & z==nz.
- scan_area_o is decoded from the registered counters, first match wins:
  - y==0 & x==0 -> 5'b00001 (INI)
  - y==0 -> 5'b00100 (area2)
  - x==0 -> 5'b01000 (area3)
  - x==nx -> 5'b10000 (area4)
  - else -> 5'b00010 (area1)
- nx=0: every y>0 sample is area3; area1 and area4 never occur. nx=ny=nz=0: a single INI sample, then DRAIN.
- sl_num_o is the one-hot of the latched cfg_sl: 0->4'b0001, 1->4'b0010, 2->4'b0100, 3->4'b1000. It is constant for the whole frame.
- start_i outside IDLE is ignored. cfg_* changes after the start is accepted have no effect.

## Timing
- Reset values: state IDLE, x/y/z=0, scan_area_o=5'b00001, sl_num_o=4'b1000, en_o=last_o=busy_o=done_o=0.
- start_i at edge t -> busy_o=1 from t+1. The first en_o can occur in cycle t+1 if ready_i=1.
- With ready_i held high: one sample per cycle, with en_o high for (nx+1)(ny+1)(nz+1) consecutive cycles.
- ready_i low stalls the scan. Coordinates and scan_area_o hold, and en_o=0.
- The last en_o is at edge L -> DRAIN from L+1. done_o is high in cycle L+PIPE_LAT, and busy_o=0 from L+PIPE_LAT+1.
- start_i in the done_o cycle is ignored (state is still DRAIN). It is accepted from the next cycle.
- rst asserted mid-frame returns every register to its reset value immediately, without waiting for a clock edge.

## Structure
- Package scan_pkg holds:
  - the state enum;
  - the five area one-hot constants (AREA_INI, AREA_1 … AREA_4);
  - the sl one-hot constants and a cfg_sl -> sl_num function;
  - the default PIPE_LAT.
- One sub-module, scan_area_dec: purely combinational decode from (x, y, nx) to scan_area_o, shared with the verification model.
- Counters and FSM stay in scan_ctrl. Target size is roughly 150–250 lines of RTL.

## Test plan
- nx=3, ny=2, nz=0, ready_i=1 -> exactly 12 en_o cycles. Area sequence is INI,a2,a2,a2, then a3,a1,a1,a4 twice. last_o on the 12th cycle, and done_o 3 cycles after it.
- Same config with ready_i toggling 1,0 -> 12 en_o, with no coordinate change on ready_i=0 cycles. Area sequence matches the first test.
- nx=0, ny=2, nz=1 -> 6 samples, z switching 0->1 after the 3rd. Areas are INI,a3,a3 for each band, and area1/area4 are never seen.
- cfg_sl_i=0 then 2 on successive frames -> sl_num_o=4'b0001, then 4'b0100. Changing cfg_sl_i mid-frame has no effect.
- abort_i during RUN at sample 5, and again during DRAIN -> IDLE next cycle, done_o never pulses. A new start then begins at x=y=z=0.
- rst pulsed mid-frame between clock edges -> all outputs at reset values immediately. start_i repeated during RUN and during the done_o cycle is ignored.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the CCSDS-123 local-difference sample-order sequencer.
// Also used by the verification model so both sides agree on the area and shift encodings.
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [4:0] AREA_INI = 5'b00001;
  localparam logic [4:0] AREA_1   = 5'b00010;
  localparam logic [4:0] AREA_2   = 5'b00100;
  localparam logic [4:0] AREA_3   = 5'b01000;
  localparam logic [4:0] AREA_4   = 5'b10000;

  localparam logic [3:0] SL_0 = 4'b0001;
  localparam logic [3:0] SL_1 = 4'b0010;
  localparam logic [3:0] SL_2 = 4'b0100;
  localparam logic [3:0] SL_3 = 4'b1000;

  localparam int PIPE_LAT_DEF = 3;

  function automatic logic [3:0] sl_to_num(input logic [1:0] sl);
    logic [3:0] num;
    num = SL_3;
    case (sl)
      2'd0:    num = SL_0;
      2'd1:    num = SL_1;
      2'd2:    num = SL_2;
      default: num = SL_3;
    endcase
    return num;
  endfunction

endpackage

// File: rtl/scan_area_dec.sv
// Scan-area classifier: maps the current column/row position to the one-hot area code.
// The checks run in priority order, so the image corner wins over the first-row and first-column cases.
module scan_area_dec
  import scan_pkg::*;
#(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 10
) (
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  input  logic [X_WIDTH-1:0] nx,
  output logic [4:0]         scan_area
);

  always_comb begin
    // NOTE: default first so every path assigns scan_area and no latch is inferred.
    scan_area = AREA_1;
    if (y == '0 && x == '0) scan_area = AREA_INI;
    else if (y == '0)       scan_area = AREA_2;
    else if (x == '0)       scan_area = AREA_3;
    else if (x == nx)       scan_area = AREA_4;
  end

endmodule

// File: rtl/scan_ctrl.sv
// BSQ sample-order sequencer: walks x, then y, then z, issuing one enable per accepted sample,
// then waits out the datapath latency before pulsing done_o.
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int X_WIDTH  = 10,
  parameter int Y_WIDTH  = 10,
  parameter int Z_WIDTH  = 8,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [X_WIDTH-1:0] cfg_nx_i,
  input  logic [Y_WIDTH-1:0] cfg_ny_i,
  input  logic [Z_WIDTH-1:0] cfg_nz_i,
  input  logic [1:0]         cfg_sl_i,
  input  logic               ready_i,
  output logic               en_o,
  output logic [X_WIDTH-1:0] x_o,
  output logic [Y_WIDTH-1:0] y_o,
  output logic [Z_WIDTH-1:0] z_o,
  output logic [4:0]         scan_area_o,
  output logic [3:0]         sl_num_o,
  output logic               last_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_END = DW'(PIPE_LAT - 1);

  state_t             state_q, state_d;
  logic [X_WIDTH-1:0] x_q, nx_q;
  logic [Y_WIDTH-1:0] y_q, ny_q;
  logic [Z_WIDTH-1:0] z_q, nz_q;
  logic [1:0]         sl_q;
  logic [DW-1:0]      drain_q;
  logic               start_acc;
  logic               x_end, y_end, z_end;

  assign x_end = (x_q == nx_q);
  assign y_end = (y_q == ny_q);
  assign z_end = (z_q == nz_q);

  assign en_o     = (state_q == ST_RUN) & ready_i;
  assign last_o   = (state_q == ST_RUN) & x_end & y_end & z_end;
  assign busy_o   = (state_q != ST_IDLE);
  assign x_o      = x_q;
  assign y_o      = y_q;
  assign z_o      = z_q;
  assign sl_num_o = sl_to_num(sl_q);

  scan_area_dec #(
    .X_WIDTH(X_WIDTH),
    .Y_WIDTH(Y_WIDTH)
  ) u_area_dec (
    .x        (x_q),
    .y        (y_q),
    .nx       (nx_q),
    .scan_area(scan_area_o)
  );

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_RUN;
          start_acc = 1'b1;
        end
      end
      ST_RUN: begin
        if (en_o && last_o) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_END) begin
          state_d = ST_IDLE;
          done_o  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a start and the completion pulse.
    if (abort_i) begin
      state_d   = ST_IDLE;
      start_acc = 1'b0;
      done_o    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
      nz_q    <= '0;
      sl_q    <= 2'd3;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == ST_DRAIN && state_d == ST_DRAIN) ? drain_q + DW'(1) : '0;
      if (start_acc) begin
        nx_q <= cfg_nx_i;
        ny_q <= cfg_ny_i;
        nz_q <= cfg_nz_i;
        sl_q <= cfg_sl_i;
        x_q  <= '0;
        y_q  <= '0;
        z_q  <= '0;
      end else if (en_o) begin
        if (!x_end) begin
          x_q <= x_q + X_WIDTH'(1);
        end else begin
          x_q <= '0;
          if (!y_end) begin
            y_q <= y_q + Y_WIDTH'(1);
          end else begin
            y_q <= '0;
            z_q <= z_end ? '0 : z_q + Z_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl: table-driven scan vectors plus hand-written abort, reset and start-ignore sequences.
module tb_scan_ctrl;
  import scan_pkg::*;

  localparam int PIPE_LAT = 3;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] z;
    logic [4:0] area;
    logic       last;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i, abort_i, ready_i;
  logic [9:0] cfg_nx_i, cfg_ny_i;
  logic [7:0] cfg_nz_i;
  logic [1:0] cfg_sl_i;
  logic       en_o, last_o, busy_o, done_o;
  logic [9:0] x_o, y_o;
  logic [7:0] z_o;
  logic [4:0] scan_area_o;
  logic [3:0] sl_num_o;

  int total = 0;
  int bad   = 0;

  vec_t       tab_a [12];
  vec_t       tab_b [6];
  vec_t       exp_q [$];
  logic [3:0] exp_sl;

  scan_ctrl #(
    .X_WIDTH(10), .Y_WIDTH(10), .Z_WIDTH(8), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .cfg_nx_i(cfg_nx_i), .cfg_ny_i(cfg_ny_i), .cfg_nz_i(cfg_nz_i), .cfg_sl_i(cfg_sl_i),
    .ready_i(ready_i), .en_o(en_o), .x_o(x_o), .y_o(y_o), .z_o(z_o),
    .scan_area_o(scan_area_o), .sl_num_o(sl_num_o), .last_o(last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},   en_o, 0);
    check({tag, "_x"},    x_o, 0);
    check({tag, "_y"},    y_o, 0);
    check({tag, "_z"},    z_o, 0);
    check({tag, "_area"}, scan_area_o, AREA_INI);
    check({tag, "_sl"},   sl_num_o, 4'b1000);
    check({tag, "_last"}, last_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
  endtask

  // Called and returns at posedge+1; leaves the DUT in the first RUN cycle with scrambled cfg inputs.
  task automatic start_frame(input logic [9:0] nx, input logic [9:0] ny, input logic [7:0] nz,
                             input logic [1:0] sl);
    cfg_nx_i = nx; cfg_ny_i = ny; cfg_nz_i = nz; cfg_sl_i = sl;
    start_i  = 1'b1;
    @(posedge clk); #1;
    start_i  = 1'b0;
    cfg_nx_i = 10'd7; cfg_ny_i = 10'd7; cfg_nz_i = 8'd3; cfg_sl_i = ~sl;
    check("start_busy", busy_o, 1);
  endtask

  task automatic run_scan(input bit toggle, input int start_at);
    int   idx = 0;
    int   cyc = 0;
    vec_t e;
    while (idx < exp_q.size() && cyc < 400) begin
      ready_i = toggle ? (cyc % 2 == 0) : 1'b1;
      start_i = (cyc == start_at);
      e = exp_q[idx];
      @(negedge clk);
      check("scan_en",   en_o, ready_i);
      check("scan_x",    x_o, e.x);
      check("scan_y",    y_o, e.y);
      check("scan_z",    z_o, e.z);
      check("scan_area", scan_area_o, e.area);
      check("scan_last", last_o, e.last);
      check("scan_sl",   sl_num_o, exp_sl);
      check("scan_busy", busy_o, 1);
      if (ready_i) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    check("scan_len", idx, exp_q.size());
  endtask

  task automatic run_drain(input bit start_in_done);
    for (int k = 1; k <= PIPE_LAT; k++) begin
      start_i = start_in_done && (k == PIPE_LAT);
      @(negedge clk);
      check("drain_done", done_o, k == PIPE_LAT);
      check("drain_busy", busy_o, 1);
      check("drain_en",   en_o, 0);
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    @(negedge clk);
    check("idle_busy", busy_o, 0);
    check("idle_done", done_o, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    tab_a = '{
      '{10'd0, 10'd0, 8'd0, AREA_INI, 1'b0}, '{10'd1, 10'd0, 8'd0, AREA_2, 1'b0},
      '{10'd2, 10'd0, 8'd0, AREA_2,   1'b0}, '{10'd3, 10'd0, 8'd0, AREA_2, 1'b0},
      '{10'd0, 10'd1, 8'd0, AREA_3,   1'b0}, '{10'd1, 10'd1, 8'd0, AREA_1, 1'b0},
      '{10'd2, 10'd1, 8'd0, AREA_1,   1'b0}, '{10'd3, 10'd1, 8'd0, AREA_4, 1'b0},
      '{10'd0, 10'd2, 8'd0, AREA_3,   1'b0}, '{10'd1, 10'd2, 8'd0, AREA_1, 1'b0},
      '{10'd2, 10'd2, 8'd0, AREA_1,   1'b0}, '{10'd3, 10'd2, 8'd0, AREA_4, 1'b1}
    };
    tab_b = '{
      '{10'd0, 10'd0, 8'd0, AREA_INI, 1'b0}, '{10'd0, 10'd1, 8'd0, AREA_3, 1'b0},
      '{10'd0, 10'd2, 8'd0, AREA_3,   1'b0}, '{10'd0, 10'd0, 8'd1, AREA_INI, 1'b0},
      '{10'd0, 10'd1, 8'd1, AREA_3,   1'b0}, '{10'd0, 10'd2, 8'd1, AREA_3, 1'b1}
    };

    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b0;
    cfg_nx_i = '0; cfg_ny_i = '0; cfg_nz_i = '0; cfg_sl_i = '0;
    #3 check_reset_outputs("rst_hold");
    #9 rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rst_idle");

    // Frame 1: 4x3x1, ready high, stray start mid-run, sl=0.
    exp_q = {}; foreach (tab_a[i]) exp_q.push_back(tab_a[i]);
    exp_sl = SL_0;
    start_frame(10'd3, 10'd2, 8'd0, 2'd0);
    run_scan(1'b0, 4);
    run_drain(1'b0);

    // Frame 2: same geometry, ready toggling, sl=2, start in the done cycle.
    exp_sl = SL_2;
    start_frame(10'd3, 10'd2, 8'd0, 2'd2);
    run_scan(1'b1, -1);
    run_drain(1'b1);

    // Frame 3: single-column image with two bands.
    exp_q = {}; foreach (tab_b[i]) exp_q.push_back(tab_b[i]);
    exp_sl = SL_1;
    start_frame(10'd0, 10'd2, 8'd1, 2'd1);
    run_scan(1'b0, -1);
    run_drain(1'b0);

    // Abort in RUN on the fifth sample.
    start_frame(10'd3, 10'd2, 8'd0, 2'd0);
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      abort_i = (i == 4);
      @(negedge clk);
      check("abrun_en", en_o, 1);
      check("abrun_x",  x_o, tab_a[i].x);
      check("abrun_y",  y_o, tab_a[i].y);
      @(posedge clk); #1;
    end
    abort_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abrun_busy", busy_o, 0);
      check("abrun_done", done_o, 0);
      check("abrun_en0",  en_o, 0);
      @(posedge clk); #1;
    end

    // Abort in DRAIN after a 1x1x1 frame.
    start_frame(10'd0, 10'd0, 8'd0, 2'd1);
    ready_i = 1'b1;
    @(negedge clk);
    check("single_en",   en_o, 1);
    check("single_last", last_o, 1);
    check("single_area", scan_area_o, AREA_INI);
    @(posedge clk); #1;
    abort_i = 1'b1;
    @(negedge clk);
    check("abdrain_busy", busy_o, 1);
    check("abdrain_done", done_o, 0);
    @(posedge clk); #1;
    abort_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abdrain_idle", busy_o, 0);
      check("abdrain_nodone", done_o, 0);
      @(posedge clk); #1;
    end

    // Restart after the aborts begins from the origin.
    exp_q = {}; foreach (tab_a[i]) exp_q.push_back(tab_a[i]);
    exp_sl = SL_0;
    start_frame(10'd3, 10'd2, 8'd0, 2'd0);
    run_scan(1'b0, -1);
    run_drain(1'b0);

    // Asynchronous reset in the middle of a frame, away from any clock edge.
    start_frame(10'd3, 10'd2, 8'd0, 2'd2);
    ready_i = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
